// File: rtl/dsp48a1_pkg.sv
// dsp48a1_pkg: DSP48A1 OPMODE field encodings, sequencer states and pipeline depths
// shared by the MAC sequencer and its tag pipe.
package dsp48a1_pkg;

   // OPMODE[1:0] X multiplexer select
   localparam logic [1:0] X_ZERO = 2'b00;
   localparam logic [1:0] X_M    = 2'b01;
   localparam logic [1:0] X_P    = 2'b10;
   localparam logic [1:0] X_DAB  = 2'b11;

   // OPMODE[3:2] Z multiplexer select
   localparam logic [1:0] Z_ZERO = 2'b00;
   localparam logic [1:0] Z_PCIN = 2'b01;
   localparam logic [1:0] Z_P    = 2'b10;
   localparam logic [1:0] Z_C    = 2'b11;

   localparam int unsigned OPM_PREADD_EN   = 4;
   localparam int unsigned OPM_CARRYIN     = 5;
   localparam int unsigned OPM_PREADD_SUB  = 6;
   localparam int unsigned OPM_POSTADD_SUB = 7;

   // Cycles after issue at which OPMODE and CEP apply, and the drain length.
   localparam int unsigned OPMODE_STAGE = 1;
   localparam int unsigned CEP_STAGE    = 2;
   localparam int unsigned DRAIN_CYC    = 3;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

   // P = Z +/- M, with Z = C on the first pair of a job and P afterwards.
   function automatic logic [7:0] opmode_f(input logic first, input logic sub);
      logic [7:0] op;
      op                  = 8'h00;
      op[1:0]             = X_M;
      op[3:2]             = first ? Z_C : Z_P;
      op[OPM_POSTADD_SUB] = sub;
      return op;
   endfunction

endpackage

// File: rtl/dsp48a1_mac_seq_tag_pipe.sv
// mac_seq_tag_pipe: shift register of {valid, first} issue tags with synchronous clear.
// The first flag is only consumed at stage 1, so it is held for that stage alone.
module mac_seq_tag_pipe #(
   parameter int unsigned Depth = 2
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             valid_i,
   input  logic             first_i,
   output logic [Depth-1:0] valid_o,
   output logic             first_o
);

   logic [Depth-1:0] valid_q;
   logic             first_q;

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         valid_q <= '0;
         first_q <= 1'b0;
      end else begin
         valid_q[0] <= valid_i;
         for (int i = 1; i < Depth; i++) begin
            valid_q[i] <= valid_q[i-1];
         end
         first_q <= valid_i & first_i;
      end
   end

   assign valid_o = valid_q;
   assign first_o = first_q;

endmodule

// File: rtl/dsp48a1_mac_seq.sv
// dsp48a1_mac_seq: runs bias +/- sum(a*b) jobs on one DSP48A1 slice and returns P.
// Optional MAC_SEQ_STALL_CNT_EN adds r_stalls, the count of RUN cycles without a pair.
module dsp48a1_mac_seq
   import dsp48a1_pkg::*;
#(
   parameter int unsigned LEN_W = 10
) (
   input  logic             clk,
   input  logic             RST_N,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [LEN_W-1:0] start_len,
   input  logic [47:0]      start_bias,
   input  logic             start_sub,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [17:0]      s_a,
   input  logic [17:0]      s_b,
   output logic             r_valid,
   input  logic             r_ready,
   output logic [47:0]      r_data,
`ifdef MAC_SEQ_STALL_CNT_EN
   output logic [15:0]      r_stalls,
`endif
   output logic [17:0]      DSP_A,
   output logic [17:0]      DSP_B,
   output logic [47:0]      DSP_C,
   output logic [7:0]       DSP_OPMODE,
   output logic             DSP_CEA,
   output logic             DSP_CEB,
   output logic             DSP_CEM,
   output logic             DSP_CEOPMODE,
   output logic             DSP_CEC,
   output logic             DSP_CEP,
   output logic             DSP_RST,
   input  logic [47:0]      DSP_P
);

   state_t                 state_q;
   logic [LEN_W-1:0]       cnt_q;
   logic                   sub_q;
   logic                   first_q;
   logic [47:0]            r_data_q;
   logic                   start_fire;
   logic                   s_fire;
   logic [CEP_STAGE-1:0]   tag_valid;
   logic                   tag_first;

   assign start_ready = (state_q == StIdle);
   assign s_ready     = (state_q == StRun);
   assign r_valid     = (state_q == StDone);
   assign r_data      = r_data_q;
   assign start_fire  = start_valid & start_ready;
   assign s_fire      = s_valid & s_ready;

   always_ff @(posedge clk) begin
      if (!RST_N) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         sub_q    <= 1'b0;
         first_q  <= 1'b0;
         r_data_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_valid) begin
                  cnt_q   <= start_len;
                  sub_q   <= start_sub;
                  first_q <= 1'b1;
                  if (start_len == '0) begin
                     r_data_q <= start_bias;
                     state_q  <= StDone;
                  end else begin
                     state_q <= StRun;
                  end
               end
            end
            StRun: begin
               if (s_valid) begin
                  cnt_q   <= cnt_q - LEN_W'(1);
                  first_q <= 1'b0;
                  if (cnt_q == LEN_W'(1)) state_q <= StDrain;
               end
            end
            StDrain: begin
               // An empty tag pipe means the last CEP pulse has already landed in P.
               if (tag_valid == '0) begin
                  r_data_q <= DSP_P;
                  state_q  <= StDone;
               end
            end
            StDone: begin
               if (r_ready) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   mac_seq_tag_pipe #(
      .Depth (CEP_STAGE)
   ) u_tag_pipe (
      .clk_i   (clk),
      .clr_i   (!RST_N),
      .valid_i (s_fire),
      .first_i (first_q),
      .valid_o (tag_valid),
      .first_o (tag_first)
   );

   always_comb begin
      DSP_OPMODE = 8'h00;
      if (tag_valid[OPMODE_STAGE-1]) DSP_OPMODE = opmode_f(tag_first, sub_q);
   end

   assign DSP_CEP      = tag_valid[CEP_STAGE-1];
   assign DSP_A        = s_a;
   assign DSP_B        = s_b;
   assign DSP_C        = start_bias;
   assign DSP_CEC      = start_fire & RST_N;
   assign DSP_CEA      = RST_N;
   assign DSP_CEB      = RST_N;
   assign DSP_CEM      = RST_N;
   assign DSP_CEOPMODE = RST_N;
   assign DSP_RST      = !RST_N;

`ifdef MAC_SEQ_STALL_CNT_EN
   logic [15:0] stalls_q;

   always_ff @(posedge clk) begin
      if (!RST_N) begin
         stalls_q <= '0;
      end else if (start_fire) begin
         stalls_q <= '0;
      end else if (s_ready && !s_valid && (stalls_q != 16'hFFFF)) begin
         stalls_q <= stalls_q + 16'd1;
      end
   end

   assign r_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
// tb_dsp48a1_mac_seq: drives jobs into the sequencer wired to a behavioural DSP48A1 slice
// and compares results, OPMODE/CEP timing and handshakes against a reference model.
module tb_dsp48a1_mac_seq;

   localparam int LEN_W = 10;

   logic             clk = 1'b0;
   logic             RST_N = 1'b0;
   logic             start_valid = 1'b0;
   logic             start_ready;
   logic [LEN_W-1:0] start_len = '0;
   logic [47:0]      start_bias = '0;
   logic             start_sub = 1'b0;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [17:0]      s_a = '0;
   logic [17:0]      s_b = '0;
   logic             r_valid;
   logic             r_ready = 1'b0;
   logic [47:0]      r_data;
`ifdef MAC_SEQ_STALL_CNT_EN
   logic [15:0]      r_stalls;
`endif
   logic [17:0]      DSP_A, DSP_B;
   logic [47:0]      DSP_C, DSP_P;
   logic [7:0]       DSP_OPMODE;
   logic             DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEOPMODE, DSP_CEC, DSP_CEP, DSP_RST;

   dsp48a1_mac_seq #(
      .LEN_W (LEN_W)
   ) dut (
      .clk          (clk),
      .RST_N        (RST_N),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .start_len    (start_len),
      .start_bias   (start_bias),
      .start_sub    (start_sub),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_a          (s_a),
      .s_b          (s_b),
      .r_valid      (r_valid),
      .r_ready      (r_ready),
      .r_data       (r_data),
`ifdef MAC_SEQ_STALL_CNT_EN
      .r_stalls     (r_stalls),
`endif
      .DSP_A        (DSP_A),
      .DSP_B        (DSP_B),
      .DSP_C        (DSP_C),
      .DSP_OPMODE   (DSP_OPMODE),
      .DSP_CEA      (DSP_CEA),
      .DSP_CEB      (DSP_CEB),
      .DSP_CEM      (DSP_CEM),
      .DSP_CEOPMODE (DSP_CEOPMODE),
      .DSP_CEC      (DSP_CEC),
      .DSP_CEP      (DSP_CEP),
      .DSP_RST      (DSP_RST),
      .DSP_P        (DSP_P)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural DSP48A1 slice: A1/B1, M, OPMODE, C and P registers, synchronous reset.
   logic [17:0]        a1_r, b1_r;
   logic signed [35:0] m_r;
   logic [7:0]         opm_r;
   logic [47:0]        c_r, p_r, xv, zv;

   always_comb begin
      xv = 48'd0;
      case (opm_r[1:0])
         2'b01:   xv = {{12{m_r[35]}}, m_r};
         2'b10:   xv = p_r;
         2'b11:   xv = {12'd0, a1_r, b1_r};
         default: xv = 48'd0;
      endcase
      zv = 48'd0;
      case (opm_r[3:2])
         2'b10:   zv = p_r;
         2'b11:   zv = c_r;
         default: zv = 48'd0;
      endcase
   end

   always @(posedge clk) begin
      if (DSP_RST) begin
         a1_r <= '0; b1_r <= '0; m_r <= '0; opm_r <= '0; c_r <= '0; p_r <= '0;
      end else begin
         if (DSP_CEA) a1_r <= DSP_A;
         if (DSP_CEB) b1_r <= DSP_B;
         if (DSP_CEM) m_r <= $signed(a1_r) * $signed(b1_r);
         if (DSP_CEOPMODE) opm_r <= DSP_OPMODE;
         if (DSP_CEC) c_r <= DSP_C;
         if (DSP_CEP) p_r <= opm_r[7] ? (zv - xv) : (zv + xv);
      end
   end
   assign DSP_P = p_r;

   int n_err = 0;
   int n_chk = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Timing monitor: OPMODE one cycle and CEP two cycles after each accepted pair.
   logic       acc_d1 = 1'b0, acc_d2 = 1'b0, mon_first = 1'b0, mon_sub = 1'b0;
   logic [7:0] pend_opm = 8'h00;
   int         cep_cnt = 0;

   always @(negedge clk) begin
      if (!RST_N) begin
         acc_d1 = 1'b0;
         acc_d2 = 1'b0;
      end else begin
         check("cep timing", DSP_CEP, acc_d2);
         check("opmode", DSP_OPMODE, acc_d1 ? pend_opm : 8'h00);
         if (DSP_CEP) cep_cnt++;
         acc_d2 = acc_d1;
         if (start_valid && start_ready) begin
            mon_first = 1'b1;
            mon_sub   = start_sub;
         end
         acc_d1 = s_valid && s_ready;
         if (acc_d1) begin
            if (mon_sub) pend_opm = mon_first ? 8'h8D : 8'h89;
            else         pend_opm = mon_first ? 8'h0D : 8'h09;
            mon_first = 1'b0;
         end
      end
   end

   // Reference job state
   logic [47:0] exp_acc = '0;
   logic        exp_sub = 1'b0;
   int          cur_len = 0, t_last = 0, t_start = 0, exp_stalls = 0;

   task automatic start_job(input logic [47:0] bias, input int len, input logic sub);
      int guard = 0;
      start_valid = 1'b1;
      start_len   = LEN_W'(len);
      start_bias  = bias;
      start_sub   = sub;
      exp_acc     = bias;
      exp_sub     = sub;
      cur_len     = len;
      exp_stalls  = 0;
      cep_cnt     = 0;
      @(negedge clk);
      while (!start_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("start handshake", start_ready, 1'b1);
      check("cec on start", DSP_CEC, 1'b1);
      check("dsp_c bias", DSP_C, bias);
      t_start = cyc;
      @(posedge clk);
      #1 start_valid = 1'b0;
   endtask

   task automatic feed(input logic [17:0] a, input logic [17:0] b, input int gap);
      logic signed [47:0] prod;
      int guard = 0;
      s_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      exp_stalls += gap;
      s_valid = 1'b1;
      s_a     = a;
      s_b     = b;
      @(negedge clk);
      while (!s_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("s_ready", s_ready, 1'b1);
      t_last  = cyc;
      prod    = $signed(a) * $signed(b);
      exp_acc = exp_sub ? (exp_acc - prod) : (exp_acc + prod);
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   task automatic finish_job(input string tag, input int hold);
      int guard = 0;
      @(negedge clk);
      while (!r_valid && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check({tag, " r_valid"}, r_valid, 1'b1);
      if (cur_len == 0) check({tag, " latency"}, 64'(cyc - t_start), 64'd1);
      else              check({tag, " latency"}, 64'(cyc - t_last), 64'd4);
      check({tag, " r_data"}, r_data, exp_acc);
      check({tag, " cep pulses"}, 64'(cep_cnt), 64'(cur_len));
`ifdef MAC_SEQ_STALL_CNT_EN
      check({tag, " r_stalls"}, r_stalls, 64'(exp_stalls));
`endif
      if (hold > 0) begin
         // Queue a len=0 job while the result is held back.
         start_valid = 1'b1;
         start_len   = '0;
         start_bias  = 48'd77;
         start_sub   = 1'b0;
         repeat (hold) begin
            @(negedge clk);
            check({tag, " hold start_ready"}, start_ready, 1'b0);
            check({tag, " hold r_valid"}, r_valid, 1'b1);
            check({tag, " hold r_data"}, r_data, exp_acc);
         end
      end
      r_ready = 1'b1;
      @(posedge clk);
      #1 r_ready = 1'b0;
      if (hold > 0) begin
         @(negedge clk);
         check({tag, " next start_ready"}, start_ready, 1'b1);
         exp_acc    = 48'd77;
         cur_len    = 0;
         exp_stalls = 0;
         cep_cnt    = 0;
         t_start    = cyc;
         @(posedge clk);
         #1 start_valid = 1'b0;
         finish_job("held next", 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] a, b;
      int          len;
      logic        sub;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst dsp_rst", DSP_RST, 1'b1);
      check("rst cea", DSP_CEA, 1'b0);
      @(posedge clk);
      #1 RST_N = 1'b1;
      @(negedge clk);
      check("rst start_ready", start_ready, 1'b1);
      check("rst s_ready", s_ready, 1'b0);
      check("rst r_valid", r_valid, 1'b0);
      check("rst r_data", r_data, 48'd0);
      check("rst cec", DSP_CEC, 1'b0);
      check("rst cep", DSP_CEP, 1'b0);
      check("cea after rst", DSP_CEA, 1'b1);
      @(posedge clk);
      #1;

      start_job(48'd100, 3, 1'b0);
      feed(18'd2, 18'd3, 0);
      feed(18'd4, 18'd5, 0);
      feed(18'd6, 18'd7, 0);
      finish_job("add", 0);
      check("add 168", r_data, 48'd168);

      start_job(48'd1000, 3, 1'b1);
      feed(18'd2, 18'd3, 0);
      feed(18'd4, 18'd5, 0);
      feed(18'd6, 18'd7, 0);
      finish_job("sub", 0);
      check("sub 932", r_data, 48'd932);

      start_job(48'd100, 3, 1'b0);
      feed(18'd2, 18'd3, 0);
      feed(18'd4, 18'd5, 2);
      feed(18'd6, 18'd7, 2);
      finish_job("stall", 0);

      start_job(48'd55, 0, 1'b0);
      finish_job("len0", 0);

      start_job(48'd100, 3, 1'b0);
      feed(18'd2, 18'd3, 0);
      feed(18'd4, 18'd5, 0);
      feed(18'd6, 18'd7, 0);
      finish_job("hold", 5);

      // Reset in the middle of a job.
      start_job(48'd500, 5, 1'b0);
      feed(18'd9, 18'd9, 0);
      feed(18'd8, 18'd8, 0);
      RST_N = 1'b0;
      @(negedge clk);
      check("abort dsp_rst", DSP_RST, 1'b1);
      @(posedge clk);
      #1 RST_N = 1'b1;
      @(negedge clk);
      check("abort r_valid", r_valid, 1'b0);
      check("abort s_ready", s_ready, 1'b0);
      check("abort start_ready", start_ready, 1'b1);
      check("abort dsp_rst low", DSP_RST, 1'b0);
      @(posedge clk);
      #1;
      start_job(48'd0, 1, 1'b0);
      feed(18'd3, 18'd3, 0);
      finish_job("after abort", 0);
      check("after abort 9", r_data, 48'd9);

      // Randomized jobs with full-range signed operands and random stalls.
      for (int j = 0; j < 8; j++) begin
         len = $urandom_range(1, 12);
         sub = 1'($urandom_range(0, 1));
         start_job({16'($urandom), 32'($urandom)}, len, sub);
         for (int i = 0; i < len; i++) begin
            a = 18'($urandom);
            b = 18'($urandom);
            feed(a, b, $urandom_range(0, 2));
         end
         finish_job("random", 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
